hadd_pulse_collector: RTL and testbench
=======================================

// Module: hadd_pulse_collector
// PURPOSE
//  Downstream consumer of the half-adder stage. Samples its carry/sum output strobes in a window
//  after each half-adder clock event and packs them into one result record per event.
//  Flags multi-pulse and window-overrun errors and buffers records in a small FIFO.
//  Records leave on a valid/ready interface towards the checker/logger.
// PARAMETERS
//  OPEN_DLY   3  cycles from clk_pulse to window open (models delay_carry/delay_sum)
//  WIN_LEN    4  window length in cycles; >=1
//  FIFO_DEPTH 4  record FIFO entries; power of two, >=2
//  CNT_W      16 width of saturating stray/drop counters
// PORTS
//  clock        in  1      single clock, rising edge
//  reset_n      in  1      asynchronous active-low reset
//  clk_pulse    in  1      1-cycle strobe: half-adder clock event
//  sum_in       in  1      1-cycle strobe from half-adder sum
//  carry_in     in  1      1-cycle strobe from half-adder carry
//  out_valid    out 1      record available
//  out_ready    in  1      consumer accepts record when out_valid&out_ready
//  out_data     out REC_W  {overrun,multi_carry,multi_sum,carry,sum}; REC_W=5 (+16 with TSTAMP)
//  stray_count  out CNT_W  strobes seen outside any open window, saturating
//  drop_count   out CNT_W  records/events lost (FIFO full or 2nd pending event), saturating
//  busy         out 1      FSM not in IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, FIFO empty, all outputs 0, pending=0.
//  FSM: IDLE -clk_pulse-> WAIT (cnt=OPEN_DLY) -cnt==1-> OPEN (cnt=WIN_LEN) -cnt==1-> COMMIT -> IDLE,
//   or COMMIT -> WAIT directly if pending set (pending cleared).
//  clk_pulse at cycle t0: window covers cycles t0+OPEN_DLY+1 .. t0+OPEN_DLY+WIN_LEN inclusive.
//  In OPEN: first sum_in sets sum, second+ sets multi_sum; same for carry/multi_carry.
//  sum_in/carry_in outside OPEN: stray_count += 1 per asserted input (both = +2), no record change.
//  clk_pulse in WAIT/OPEN/COMMIT: current record overrun=1; pending=1; if pending already 1 ->
//   drop_count += 1, event discarded.
//  clk_pulse and window-closing cycle together: treated as in OPEN (overrun+pending).
//  COMMIT: push record; record bits cleared. Latency: out_valid high at cycle t0+OPEN_DLY+WIN_LEN+2
//   when FIFO was empty.
//  FIFO: push accepted if not full, or full with pop in same cycle; else drop_count += 1.
//   Pop on out_valid&out_ready; out_data registered head; out_data=0 when empty.
//   Pointers wrap modulo FIFO_DEPTH with extra wrap bit for full/empty.
//  Counters saturate at all-ones; never wrap.
// CONFIGURATION
//  HADD_COLL_TSTAMP_EN defined: out_data gains [20:5] = free-running 16-bit cycle counter value
//   latched at the clk_pulse that started the window (wraps mod 2^16); counter resets to 0.
//  Not defined: REC_W=5, no timestamp counter logic.
// STRUCTURE
//  Package hadd_coll_pkg: state enum (IDLE,WAIT,OPEN,COMMIT), record struct, REC_W and field
//   index constants, TS_W=16.
//  Sub-module hadd_coll_fifo: parameterised sync FIFO (width, depth), registered output,
//   full/empty, push/pop.
// TESTING
//  reset_n low mid-OPEN with sum_in pulses -> all outputs 0; after release no record until new clk_pulse.
//  clk_pulse@0, sum_in@5, carry_in@6 -> out_valid@9, out_data=5'b00011; stray_count=0.
//  clk_pulse@0, sum_in@4 and @7, sum_in@8 -> record 5'b00101; stray_count=1.
//  clk_pulse@0 and @5, @6 -> 1st record overrun=1, 2nd window starts after COMMIT, drop_count=1.
//  out_ready=0, 5 events, one sum each -> 4 records held, drop_count=1; then out_ready=1 drains
//   4 records in order.
//  TSTAMP_EN: clk_pulse at cycle 100 after reset -> out_data[20:5]=100.

Source files
------------

// File: rtl/hadd_coll_pkg.sv
// Shared state, record layout and helpers for hadd_pulse_collector.
// HADD_COLL_TSTAMP_EN widens each record by a 16-bit timestamp field.
package hadd_coll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    OPEN   = 2'd2,
    COMMIT = 2'd3
  } coll_state_t;

  typedef struct packed {
    logic overrun;
    logic multi_carry;
    logic multi_sum;
    logic carry;
    logic sum;
  } coll_rec_t;

  localparam int TS_W   = 16;
  localparam int FLAG_W = 5;

  localparam int IDX_SUM         = 0;
  localparam int IDX_CARRY       = 1;
  localparam int IDX_MULTI_SUM   = 2;
  localparam int IDX_MULTI_CARRY = 3;
  localparam int IDX_OVERRUN     = 4;
  localparam int IDX_TS_LSB      = 5;

`ifdef HADD_COLL_TSTAMP_EN
  localparam int REC_W = FLAG_W + TS_W;
`else
  localparam int REC_W = FLAG_W;
`endif

  function automatic logic [1:0] strobe_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/hadd_coll_fifo.sv
// Synchronous record FIFO with registered head output; reads as zero when empty.
// Pointers carry an extra wrap bit to tell full from empty.
module hadd_coll_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_req,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_nxt;
  logic [AW:0]      rd_nxt;
  logic             pop;
  logic             accept;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = pop_req & ~empty;
  assign accept = push & (~full | pop);
  assign wr_nxt = wr_ptr + (AW+1)'(accept);
  assign rd_nxt = rd_ptr + (AW+1)'(pop);

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Head register tracks the entry at the post-update read pointer, bypassing a same-cycle write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata  <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (wr_nxt == rd_nxt)
        rdata <= '0;
      else if (accept && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0]))
        rdata <= wdata;
      else
        rdata <= mem[rd_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/hadd_pulse_collector.sv
// Collects half-adder sum/carry strobes in a window after each clk_pulse into FIFO'd records.
// Define HADD_COLL_TSTAMP_EN to stamp each record with the cycle count of its starting clk_pulse.
//   state  | meaning
//   IDLE   | no event in flight
//   WAIT   | counting down OPEN_DLY after clk_pulse
//   OPEN   | sampling strobes for WIN_LEN cycles
//   COMMIT | push record; restart if an event is pending
module hadd_pulse_collector
  import hadd_coll_pkg::*;
#(
  parameter int OPEN_DLY   = 3,
  parameter int WIN_LEN    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clk_pulse,
  input  logic             sum_in,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REC_W-1:0] out_data,
  output logic [CNT_W-1:0] stray_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  localparam int TMR_MAX = (OPEN_DLY > WIN_LEN) ? OPEN_DLY : WIN_LEN;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] TC_OPEN = TW'(OPEN_DLY);
  localparam logic [TW-1:0] TC_WIN  = TW'(WIN_LEN);
  localparam logic [TW-1:0] TC_ONE  = TW'(1);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [1:0]  rst_sync;
  logic        rst_int_n;
  coll_state_t state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  coll_rec_t   rec, rec_nxt, push_rec;
  logic        pending, pending_nxt;
  logic        push, ev_drop, fifo_drop;
  logic        fifo_full, fifo_empty;
  logic [1:0]  stray_inc, drop_inc;
  logic [REC_W-1:0] fifo_wdata;

  // Reset asserts immediately but releases two clocks later, aligned to the clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= IDLE;
      tmr         <= '0;
      rec         <= '0;
      pending     <= 1'b0;
      stray_count <= '0;
      drop_count  <= '0;
    end else begin
      state       <= state_nxt;
      tmr         <= tmr_nxt;
      rec         <= rec_nxt;
      pending     <= pending_nxt;
      stray_count <= sat_add(stray_count, stray_inc);
      drop_count  <= sat_add(drop_count, drop_inc);
    end
  end

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    rec_nxt     = rec;
    pending_nxt = pending;
    push        = 1'b0;
    ev_drop     = 1'b0;
    push_rec    = '0;
    stray_inc   = (state == OPEN) ? 2'd0 : strobe_count(sum_in, carry_in);

    // A new event while busy marks the current record; only one event may wait behind it.
    if (clk_pulse && (state != IDLE)) begin
      rec_nxt.overrun = 1'b1;
      if (pending) ev_drop = 1'b1;
      else         pending_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (clk_pulse) begin
          state_nxt = WAIT;
          tmr_nxt   = TC_OPEN;
        end
      end
      WAIT: begin
        if (tmr == TC_ONE) begin
          state_nxt = OPEN;
          tmr_nxt   = TC_WIN;
        end else begin
          tmr_nxt = tmr - TC_ONE;
        end
      end
      OPEN: begin
        if (sum_in) begin
          if (rec.sum) rec_nxt.multi_sum = 1'b1;
          else         rec_nxt.sum       = 1'b1;
        end
        if (carry_in) begin
          if (rec.carry) rec_nxt.multi_carry = 1'b1;
          else           rec_nxt.carry       = 1'b1;
        end
        if (tmr == TC_ONE) state_nxt = COMMIT;
        else               tmr_nxt   = tmr - TC_ONE;
      end
      COMMIT: begin
        push     = 1'b1;
        push_rec = rec_nxt;
        rec_nxt  = '0;
        if (pending_nxt) begin
          state_nxt   = WAIT;
          tmr_nxt     = TC_OPEN;
          pending_nxt = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef HADD_COLL_TSTAMP_EN
  logic [TS_W-1:0] ts_cnt, ts_cur, ts_pend;

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ts_cnt  <= '0;
      ts_cur  <= '0;
      ts_pend <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if ((state == IDLE) && clk_pulse)
        ts_cur <= ts_cnt;
      else if ((state == COMMIT) && (state_nxt == WAIT))
        ts_cur <= pending ? ts_pend : ts_cnt;
      if (clk_pulse && (state != IDLE) && !pending)
        ts_pend <= ts_cnt;
    end
  end

  assign fifo_wdata = {ts_cur, push_rec};
`else
  assign fifo_wdata = push_rec;
`endif

  assign fifo_drop = push & fifo_full & ~(out_ready & ~fifo_empty);
  assign drop_inc  = {1'b0, ev_drop} + {1'b0, fifo_drop};
  assign out_valid = ~fifo_empty;
  assign busy      = (state != IDLE);

  hadd_coll_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (rst_int_n),
    .push    (push),
    .wdata   (fifo_wdata),
    .pop_req (out_ready),
    .rdata   (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_hadd_pulse_collector.sv
// Directed and random checks of hadd_pulse_collector against an event-level reference model.
module tb_hadd_pulse_collector;
  import hadd_coll_pkg::*;

  localparam int OPEN_DLY   = 3;
  localparam int WIN_LEN    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clk_pulse = 1'b0;
  logic sum_in = 1'b0;
  logic carry_in = 1'b0;
  logic out_ready = 1'b0;
  logic             out_valid;
  logic [REC_W-1:0] out_data;
  logic [CNT_W-1:0] stray_count;
  logic [CNT_W-1:0] drop_count;
  logic             busy;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clock = ~clock;

  hadd_pulse_collector #(
    .OPEN_DLY   (OPEN_DLY),
    .WIN_LEN    (WIN_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clk_pulse   (clk_pulse),
    .sum_in      (sum_in),
    .carry_in    (carry_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .stray_count (stray_count),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  // Reference model: one active event identified by its start cycle, plus a queue of records.
  logic [REC_W-1:0] m_q[$];
  bit m_act, m_pend, m_s, m_c, m_ms, m_mc, m_ovr;
  int m_start, m_stamp, m_pend_t, m_stray, m_drop, tcnt;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic void model_clear();
    m_q.delete();
    m_act = 0; m_pend = 0; m_s = 0; m_c = 0; m_ms = 0; m_mc = 0; m_ovr = 0;
    m_start = 0; m_stamp = 0; m_pend_t = 0; m_stray = 0; m_drop = 0; tcnt = 0;
  endfunction

  function automatic void model_step(input bit p, input bit s, input bit c, input bit r);
    int d;
    bit open_w, commit_w;
    logic [REC_W-1:0] rec;
    d = tcnt - m_start;
    if (r && (m_q.size() > 0)) void'(m_q.pop_front());
    open_w   = m_act && (d >= OPEN_DLY + 1) && (d <= OPEN_DLY + WIN_LEN);
    commit_w = m_act && (d == OPEN_DLY + WIN_LEN + 1);
    if (open_w) begin
      if (s) begin if (m_s) m_ms = 1; else m_s = 1; end
      if (c) begin if (m_c) m_mc = 1; else m_c = 1; end
    end else begin
      m_stray = sat(m_stray + int'(s) + int'(c));
    end
    if (p) begin
      if (!m_act) begin
        m_act = 1; m_start = tcnt; m_stamp = tcnt;
      end else begin
        m_ovr = 1;
        if (m_pend) m_drop = sat(m_drop + 1);
        else begin m_pend = 1; m_pend_t = tcnt; end
      end
    end
    if (commit_w) begin
      rec = '0;
      rec[IDX_SUM] = m_s;
      rec[IDX_CARRY] = m_c;
      rec[IDX_MULTI_SUM] = m_ms;
      rec[IDX_MULTI_CARRY] = m_mc;
      rec[IDX_OVERRUN] = m_ovr;
`ifdef HADD_COLL_TSTAMP_EN
      rec[REC_W-1:IDX_TS_LSB] = m_stamp[15:0];
`endif
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(rec);
      else m_drop = sat(m_drop + 1);
      m_s = 0; m_c = 0; m_ms = 0; m_mc = 0; m_ovr = 0;
      if (m_pend) begin
        m_start = tcnt; m_stamp = m_pend_t; m_pend = 0;
      end else begin
        m_act = 0;
      end
    end
    tcnt++;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [REC_W-1:0] head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    chk("valid", 32'(out_valid), 32'(m_q.size() > 0));
    chk("data", 32'(out_data), 32'(head));
    chk("stray", 32'(stray_count), 32'(m_stray));
    chk("drop", 32'(drop_count), 32'(m_drop));
    chk("busy", 32'(busy), 32'(m_act));
  endtask

  task automatic cycle(input bit p, input bit s, input bit c, input bit r);
    clk_pulse = p; sum_in = s; carry_in = c; out_ready = r;
    model_step(p, s, c, r);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic pattern(input int len, input logic [63:0] pm, input logic [63:0] sm,
                         input logic [63:0] cm, input logic [63:0] rm);
    for (int i = 0; i < len; i++) cycle(pm[i], sm[i], cm[i], rm[i]);
  endtask

  task automatic do_reset();
    clk_pulse = 0; sum_in = 0; carry_in = 0; out_ready = 0;
    reset_n = 0;
    model_clear();
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    repeat (2) @(posedge clock);
    #1;
    check_all();
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // pulse@0, sum@5, carry@6 -> record at cycle 9
    pattern(8, 64'h1, 64'h20, 64'h40, '1);
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    cycle(0, 0, 0, 1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data[FLAG_W-1:0]), 32'h03);
    chk("t1_stray", 32'(stray_count), 32'd0);

    // sum@4 (first in window), @7 (multi), @8 (commit cycle -> stray)
    do_reset();
    pattern(9, 64'h1, 64'h190, 64'h0, '1);
    chk("t2_data", 32'(out_data[FLAG_W-1:0]), 32'h05);
    chk("t2_stray", 32'(stray_count), 32'd1);

    // pulses @0, @5, @6 -> overrun, pending, one drop
    do_reset();
    pattern(9, 64'h61, 64'h0, 64'h0, '1);
    chk("t3_data", 32'(out_data[FLAG_W-1:0]), 32'h10);
    chk("t3_drop", 32'(drop_count), 32'd1);
    chk("t3_busy", 32'(busy), 32'd1);
    pattern(8, 64'h0, 64'h0, 64'h0, '1);
    chk("t3_second_valid", 32'(out_valid), 32'd1);
    chk("t3_second_data", 32'(out_data[FLAG_W-1:0]), 32'h00);

    // five events with out_ready low: four held, one dropped, then drained in order
    do_reset();
    pattern(50, 64'h0000_0100_4010_0401, 64'h0000_2008_0200_8020, 64'h0, 64'h0);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_drop", 32'(drop_count), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", 32'(out_data[FLAG_W-1:0]), 32'h01);
      cycle(0, 0, 0, 1);
    end
    chk("t4_empty", 32'(out_valid), 32'd0);

    // async reset in the middle of an open window
    do_reset();
    pattern(6, 64'h1, 64'h34, 64'h0, '1);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    sum_in = 1;
    reset_n = 0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_data", 32'(out_data), 32'd0);
    chk("t5_stray", 32'(stray_count), 32'd0);
    chk("t5_drop", 32'(drop_count), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    do_reset();
    pattern(12, 64'h0, 64'h0, 64'h0, '1);
    chk("t5_no_record", 32'(out_valid), 32'd0);

`ifdef HADD_COLL_TSTAMP_EN
    do_reset();
    for (int i = 0; i < 100; i++) cycle(0, 0, 0, 1);
    pattern(9, 64'h1, 64'h0, 64'h0, '1);
    chk("ts_value", 32'(out_data[REC_W-1:IDX_TS_LSB]), 32'd100);
`endif

    // random traffic, mostly-ready consumer
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);

    // random traffic, mostly-stalled consumer to exercise full FIFO
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
